// File: rtl/membus_arb_if.sv
// Bus bundle between the four requesters, the core array and membus_arb.
// slave: arbiter view. master: requester/core side view.
interface membus_arb_if;
    logic [3:0]  rq_cyc;
    logic [3:0]  rd_rq;
    logic [3:0]  wr_rq;
    logic [17:0] ma_p0;
    logic [17:0] ma_p1;
    logic [17:0] ma_p2;
    logic [17:0] ma_p3;
    logic [35:0] mb_in_p0;
    logic [35:0] mb_in_p1;
    logic [35:0] mb_in_p2;
    logic [35:0] mb_in_p3;
    logic [3:0]  wr_rs;
    logic [3:0]  addr_ack;
    logic [3:0]  rd_rs;
    logic [35:0] mb_out;
    logic        busy;
    logic [17:0] core_addr;
    logic        core_rd;
    logic        core_we;
    logic [35:0] core_wdata;
    logic [35:0] core_rdata;

    modport slave (
        input  rq_cyc, rd_rq, wr_rq,
        input  ma_p0, ma_p1, ma_p2, ma_p3,
        input  mb_in_p0, mb_in_p1, mb_in_p2, mb_in_p3,
        input  wr_rs, core_rdata,
        output addr_ack, rd_rs, mb_out, busy,
        output core_addr, core_rd, core_we, core_wdata
    );

    modport master (
        output rq_cyc, rd_rq, wr_rq,
        output ma_p0, ma_p1, ma_p2, ma_p3,
        output mb_in_p0, mb_in_p1, mb_in_p2, mb_in_p3,
        output wr_rs, core_rdata,
        input  addr_ack, rd_rs, mb_out, busy,
        input  core_addr, core_rd, core_we, core_wdata
    );
endinterface

// File: rtl/membus_arb.sv
// Four-port arbiter sharing one core array, one read/restore/write cycle at a time.
// MEMBUS_ARB_ROTATE_EN selects round-robin arbitration; fixed p0>p1>p2>p3 otherwise.
module membus_arb (
    input  logic         clk,
    input  logic         reset,
    membus_arb_if.slave  bus
);

    localparam int unsigned NP = 4;
    localparam int unsigned PW = 2;
    localparam int unsigned AW = 18;
    localparam int unsigned DW = 36;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACK   = 3'd1,
        S_RDW   = 3'd2,
        S_RS    = 3'd3,
        S_WWAIT = 3'd4,
        S_WR    = 3'd5,
        S_REC   = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   port_q, port_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [DW-1:0]   buf_q, buf_d;

    logic [NP-1:0]   addr_ack_q, addr_ack_d;
    logic [NP-1:0]   rd_rs_q, rd_rs_d;
    logic [DW-1:0]   mb_out_q, mb_out_d;
    logic            busy_q, busy_d;
    logic [AW-1:0]   core_addr_q, core_addr_d;
    logic            core_rd_q, core_rd_d;
    logic            core_we_q, core_we_d;
    logic [DW-1:0]   core_wdata_q, core_wdata_d;

    logic [NP-1:0]   eligible_c;
    logic [PW-1:0]   grant_c;
    logic            grant_vld_c;
    logic [AW-1:0]   ma_c    [NP];
    logic [DW-1:0]   mb_in_c [NP];

    assign ma_c[0]    = bus.ma_p0;
    assign ma_c[1]    = bus.ma_p1;
    assign ma_c[2]    = bus.ma_p2;
    assign ma_c[3]    = bus.ma_p3;
    assign mb_in_c[0] = bus.mb_in_p0;
    assign mb_in_c[1] = bus.mb_in_p1;
    assign mb_in_c[2] = bus.mb_in_p2;
    assign mb_in_c[3] = bus.mb_in_p3;

    // A cycle request without a read or write flag is not a real request.
    assign eligible_c = bus.rq_cyc & (bus.rd_rq | bus.wr_rq);

`ifdef MEMBUS_ARB_ROTATE_EN
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] cand_c;

    // Search starts one past the last granted port.
    always_comb begin
        grant_c     = '0;
        grant_vld_c = 1'b0;
        cand_c      = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            cand_c = ptr_q + PW'(k) + PW'(1);
            if (!grant_vld_c && eligible_c[cand_c]) begin
                grant_c     = cand_c;
                grant_vld_c = 1'b1;
            end
        end
    end

    assign ptr_d = (state_q == S_IDLE && grant_vld_c) ? grant_c : ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= PW'(NP - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant_c     = '0;
        grant_vld_c = 1'b0;
        for (int unsigned k = 0; k < NP; k++) begin
            if (!grant_vld_c && eligible_c[PW'(k)]) begin
                grant_c     = PW'(k);
                grant_vld_c = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_vld_c) state_d = S_ACK;
            S_ACK:   state_d = rd_q ? S_RDW : S_WWAIT;
            S_RDW:   state_d = S_RS;
            S_RS:    state_d = wr_q ? S_WWAIT : S_WR;
            S_WWAIT: if (bus.wr_rs[port_q]) state_d = S_WR;
            S_WR:    state_d = S_REC;
            S_REC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates follow the current state; outputs are decoded from the
    // next state so every strobe is registered and aligned with its state.
    always_comb begin
        port_d       = port_q;
        addr_d       = addr_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        buf_d        = buf_q;
        addr_ack_d   = '0;
        rd_rs_d      = '0;
        core_rd_d    = 1'b0;
        core_we_d    = 1'b0;
        mb_out_d     = mb_out_q;
        core_addr_d  = core_addr_q;
        core_wdata_d = core_wdata_q;
        busy_d       = (state_d != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (grant_vld_c) begin
                    port_d = grant_c;
                    addr_d = ma_c[grant_c];
                    rd_d   = bus.rd_rq[grant_c];
                    wr_d   = bus.wr_rq[grant_c];
                end
            end
            S_RDW:   buf_d = bus.core_rdata;
            S_WWAIT: if (bus.wr_rs[port_q]) buf_d = mb_in_c[port_q];
            default: ;
        endcase

        case (state_d)
            S_ACK: begin
                addr_ack_d  = NP'(1'b1) << port_d;
                core_addr_d = addr_d;
                core_rd_d   = rd_d;
            end
            S_RS: begin
                rd_rs_d  = NP'(1'b1) << port_d;
                mb_out_d = buf_d;
            end
            S_WR: begin
                core_we_d    = 1'b1;
                core_wdata_d = buf_d;
                core_addr_d  = addr_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_q       <= '0;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            buf_q        <= '0;
            addr_ack_q   <= '0;
            rd_rs_q      <= '0;
            mb_out_q     <= '0;
            busy_q       <= 1'b0;
            core_addr_q  <= '0;
            core_rd_q    <= 1'b0;
            core_we_q    <= 1'b0;
            core_wdata_q <= '0;
        end else begin
            port_q       <= port_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            buf_q        <= buf_d;
            addr_ack_q   <= addr_ack_d;
            rd_rs_q      <= rd_rs_d;
            mb_out_q     <= mb_out_d;
            busy_q       <= busy_d;
            core_addr_q  <= core_addr_d;
            core_rd_q    <= core_rd_d;
            core_we_q    <= core_we_d;
            core_wdata_q <= core_wdata_d;
        end
    end

    assign bus.addr_ack   = addr_ack_q;
    assign bus.rd_rs      = rd_rs_q;
    assign bus.mb_out     = mb_out_q;
    assign bus.busy       = busy_q;
    assign bus.core_addr  = core_addr_q;
    assign bus.core_rd    = core_rd_q;
    assign bus.core_we    = core_we_q;
    assign bus.core_wdata = core_wdata_q;

endmodule

// File: tb/tb_membus_arb.sv
// Self-checking bench for membus_arb: directed scenarios plus randomized single
// transactions checked against a cycle-count/memory reference model.
module tb_membus_arb;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    membus_arb_if bus ();

    membus_arb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [35:0] core_mem [256];
    logic [35:0] ref_mem  [256];
    logic [35:0] exp_mb;

    // Core array: read data appears the cycle after core_rd.
    always @(posedge clk) begin
        if (bus.core_rd) bus.core_rdata <= core_mem[bus.core_addr[7:0]];
        if (bus.core_we) core_mem[bus.core_addr[7:0]] = bus.core_wdata;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.rq_cyc = '0; bus.rd_rq = '0; bus.wr_rq = '0; bus.wr_rs = '0;
        bus.ma_p0 = '0; bus.ma_p1 = '0; bus.ma_p2 = '0; bus.ma_p3 = '0;
        bus.mb_in_p0 = '0; bus.mb_in_p1 = '0; bus.mb_in_p2 = '0; bus.mb_in_p3 = '0;
    endtask

    task automatic set_port(input int p, input logic [17:0] a, input logic [35:0] d);
        case (p)
            0: begin bus.ma_p0 = a; bus.mb_in_p0 = d; end
            1: begin bus.ma_p1 = a; bus.mb_in_p1 = d; end
            2: begin bus.ma_p2 = a; bus.mb_in_p2 = d; end
            default: begin bus.ma_p3 = a; bus.mb_in_p3 = d; end
        endcase
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({bus.addr_ack, bus.rd_rs, bus.busy, bus.core_rd, bus.core_we} !== 11'd0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0",
                     {bus.addr_ack, bus.rd_rs, bus.busy, bus.core_rd, bus.core_we});
        end
        checks++;
        if (bus.mb_out !== 36'd0) begin
            failures++; $display("FAIL reset_mb_out got=%o exp=0", bus.mb_out);
        end
        checks++;
        if (bus.core_addr !== 18'd0) begin
            failures++; $display("FAIL reset_core_addr got=%o exp=0", bus.core_addr);
        end
        checks++;
        if (bus.core_wdata !== 36'd0) begin
            failures++; $display("FAIL reset_core_wdata got=%o exp=0", bus.core_wdata);
        end
        exp_mb = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ignored();
        bus.rq_cyc = 4'b0100;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.addr_ack !== 4'd0) begin
                failures++;
                $display("FAIL ignored c%0d busy=%b addr_ack=%b exp busy=0 addr_ack=0000",
                         c, bus.busy, bus.addr_ack);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_read_only();
        logic [35:0] v;
        v = 36'o111777222666;
        core_mem[28] = v;
        ref_mem[28]  = v;
        bus.rq_cyc = 4'b0001; bus.rd_rq = 4'b0001; bus.ma_p0 = 18'o000034;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (bus.addr_ack !== 4'b0001 || bus.core_rd !== 1'b1 || bus.core_addr !== 18'o34) begin
                    failures++;
                    $display("FAIL ro_ack got ack=%b rd=%b addr=%o exp ack=0001 rd=1 addr=34",
                             bus.addr_ack, bus.core_rd, bus.core_addr);
                end
                bus.rq_cyc = '0;
            end
            if (c == 3) begin
                exp_mb = v;
                checks++;
                if (bus.rd_rs !== 4'b0001 || bus.mb_out !== v) begin
                    failures++;
                    $display("FAIL ro_rs got rd_rs=%b mb_out=%o exp rd_rs=0001 mb_out=%o",
                             bus.rd_rs, bus.mb_out, v);
                end
            end
            checks++;
            if (bus.core_we !== (c == 4)) begin
                failures++; $display("FAIL ro_we c%0d got=%b exp=%b", c, bus.core_we, (c == 4));
            end
            if (c == 4) begin
                checks++;
                if (bus.core_wdata !== v || bus.core_addr !== 18'o34) begin
                    failures++;
                    $display("FAIL ro_wdata got=%o addr=%o exp=%o addr=34",
                             bus.core_wdata, bus.core_addr, v);
                end
            end
            checks++;
            if (bus.busy !== (c < 6)) begin
                failures++; $display("FAIL ro_busy c%0d got=%b exp=%b", c, bus.busy, (c < 6));
            end
        end
        clear_inputs();
    endtask

    task automatic test_rmw();
        bus.rq_cyc = 4'b0100; bus.rd_rq = 4'b0100; bus.wr_rq = 4'b0100;
        bus.ma_p2 = 18'o000020; bus.mb_in_p2 = 36'o000000000333;
        bus.wr_rs = 4'b0011;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 3) begin
                exp_mb = ref_mem[16];
                checks++;
                if (bus.rd_rs !== 4'b0100 || bus.mb_out !== exp_mb) begin
                    failures++;
                    $display("FAIL rmw_rs got rd_rs=%b mb_out=%o exp rd_rs=0100 mb_out=%o",
                             bus.rd_rs, bus.mb_out, exp_mb);
                end
            end
            checks++;
            if (bus.core_we !== (c == 9)) begin
                failures++; $display("FAIL rmw_we c%0d got=%b exp=%b", c, bus.core_we, (c == 9));
            end
            if (c == 9) begin
                checks++;
                if (bus.core_wdata !== 36'o333 || bus.core_addr !== 18'o20) begin
                    failures++;
                    $display("FAIL rmw_wdata got=%o addr=%o exp=333 addr=20",
                             bus.core_wdata, bus.core_addr);
                end
            end
            checks++;
            if (bus.busy !== (c < 11)) begin
                failures++; $display("FAIL rmw_busy c%0d got=%b exp=%b", c, bus.busy, (c < 11));
            end
            if (c == 1) bus.rq_cyc = '0;
            if (c == 8) bus.wr_rs[2] = 1'b1;
        end
        ref_mem[16] = 36'o333;
        checks++;
        if (core_mem[16] !== 36'o333) begin
            failures++; $display("FAIL rmw_mem got=%o exp=333", core_mem[16]);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int p, op, tw, wrc, last, e;
            logic rd, wr, drop_early;
            logic [7:0]  a;
            logic [35:0] d, rdat, wdat;
            logic [3:0]  pbit, exp_ack, exp_rs;
            p = $urandom_range(3, 0);
            op = $urandom_range(2, 0);
            rd = (op != 1);
            wr = (op != 0);
            a = 8'($urandom);
            d = {4'($urandom), $urandom};
            tw = $urandom_range(6, 0);
            drop_early = 1'($urandom);
            pbit = 4'b0001 << p;
            for (int k = 0; k < 4; k++)
                if (k != p) set_port(k, 18'($urandom), {4'($urandom), $urandom});
            set_port(p, {10'd0, a}, d);
            bus.rq_cyc = 4'($urandom) | pbit;
            bus.rd_rq = rd ? pbit : 4'd0;
            bus.wr_rq = wr ? pbit : 4'd0;
            bus.wr_rs = 4'($urandom) & ~pbit;
            if (tw == 0) bus.wr_rs = bus.wr_rs | pbit;
            rdat = ref_mem[a];
            wdat = wr ? d : rdat;
            e = rd ? 4 : 2;
            wrc = (rd && !wr) ? 4 : ((tw > e) ? tw : e) + 1;
            last = wrc + 2;
            for (int c = 1; c <= last; c++) begin
                tick();
                exp_ack = (c == 1) ? pbit : 4'd0;
                exp_rs = (rd && c == 3) ? pbit : 4'd0;
                if (rd && c == 3) exp_mb = rdat;
                checks++;
                if (bus.addr_ack !== exp_ack) begin
                    failures++; $display("FAIL rand%0d c%0d addr_ack got=%b exp=%b", t, c, bus.addr_ack, exp_ack);
                end
                checks++;
                if (bus.rd_rs !== exp_rs) begin
                    failures++; $display("FAIL rand%0d c%0d rd_rs got=%b exp=%b", t, c, bus.rd_rs, exp_rs);
                end
                checks++;
                if (bus.mb_out !== exp_mb) begin
                    failures++; $display("FAIL rand%0d c%0d mb_out got=%o exp=%o", t, c, bus.mb_out, exp_mb);
                end
                checks++;
                if (bus.core_rd !== (rd && c == 1) || bus.core_we !== (c == wrc)) begin
                    failures++;
                    $display("FAIL rand%0d c%0d strobes got rd=%b we=%b exp rd=%b we=%b",
                             t, c, bus.core_rd, bus.core_we, (rd && c == 1), (c == wrc));
                end
                checks++;
                if (bus.busy !== (c < last)) begin
                    failures++; $display("FAIL rand%0d c%0d busy got=%b exp=%b", t, c, bus.busy, (c < last));
                end
                if (c == 1 || c == wrc) begin
                    checks++;
                    if (bus.core_addr !== {10'd0, a}) begin
                        failures++; $display("FAIL rand%0d c%0d core_addr got=%o exp=%o", t, c, bus.core_addr, a);
                    end
                end
                if (c == wrc) begin
                    checks++;
                    if (bus.core_wdata !== wdat) begin
                        failures++; $display("FAIL rand%0d core_wdata got=%o exp=%o", t, bus.core_wdata, wdat);
                    end
                end
                if (c == 1 && drop_early) bus.rq_cyc[p] = 1'b0;
                if (c == tw) bus.wr_rs = bus.wr_rs | pbit;
                if (c == wrc + 1) begin
                    bus.rq_cyc = '0; bus.rd_rq = '0; bus.wr_rq = '0;
                end
            end
            bus.wr_rs = '0;
            ref_mem[a] = wdat;
            checks++;
            if (core_mem[a] !== ref_mem[a]) begin
                failures++; $display("FAIL rand%0d mem[%0d] got=%o exp=%o", t, a, core_mem[a], ref_mem[a]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ack, exp_rs;
        logic       exp_busy;
        bus.rq_cyc = 4'b0001; bus.rd_rq = 4'b0001; bus.ma_p0 = 18'd40;
        bus.ma_p3 = 18'd41;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_ack = (c == 1) ? 4'b0001 : (c == 7) ? 4'b1000 : 4'd0;
            exp_rs = (c == 3) ? 4'b0001 : (c == 9) ? 4'b1000 : 4'd0;
            exp_busy = (c < 6) || (c >= 7 && c < 12);
            if (c == 3) exp_mb = ref_mem[40];
            if (c == 9) exp_mb = ref_mem[41];
            checks++;
            if (bus.addr_ack !== exp_ack || bus.rd_rs !== exp_rs) begin
                failures++;
                $display("FAIL b2b c%0d got ack=%b rs=%b exp ack=%b rs=%b",
                         c, bus.addr_ack, bus.rd_rs, exp_ack, exp_rs);
            end
            checks++;
            if (bus.busy !== exp_busy || bus.mb_out !== exp_mb) begin
                failures++;
                $display("FAIL b2b c%0d got busy=%b mb=%o exp busy=%b mb=%o",
                         c, bus.busy, bus.mb_out, exp_busy, exp_mb);
            end
            if (c == 1) begin bus.rq_cyc = '0; bus.rd_rq = '0; end
            if (c == 2) begin bus.rq_cyc = 4'b1000; bus.rd_rq = 4'b1000; end
            if (c == 7) begin bus.rq_cyc = '0; bus.rd_rq = '0; end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic [35:0] old;
        old = core_mem[5];
        bus.rq_cyc = 4'b0010; bus.wr_rq = 4'b0010; bus.ma_p1 = 18'd5;
        bus.mb_in_p1 = {4'($urandom), $urandom} ^ old;
        tick(); tick(); tick();
        bus.wr_rs = 4'b0010;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.addr_ack, bus.rd_rs, bus.busy, bus.core_rd, bus.core_we} !== 11'd0
            || bus.mb_out !== 36'd0 || bus.core_addr !== 18'd0 || bus.core_wdata !== 36'd0) begin
            failures++;
            $display("FAIL rstmid_outputs got busy=%b we=%b addr=%o mb=%o exp all 0",
                     bus.busy, bus.core_we, bus.core_addr, bus.mb_out);
        end
        exp_mb = '0;
        bus.rq_cyc = '0; bus.wr_rq = '0;
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (bus.core_we !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_replay c%0d got we=%b busy=%b exp we=0 busy=0",
                         c, bus.core_we, bus.busy);
            end
        end
        checks++;
        if (core_mem[5] !== old) begin
            failures++; $display("FAIL rstmid_mem got=%o exp=%o", core_mem[5], old);
        end
        bus.wr_rs = '0;
        bus.rq_cyc = 4'b0010; bus.rd_rq = 4'b0010; bus.ma_p1 = 18'd9;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (bus.addr_ack !== 4'b0010) begin
                    failures++; $display("FAIL rstmid_grant got=%b exp=0010", bus.addr_ack);
                end
                bus.rq_cyc = '0; bus.rd_rq = '0;
            end
            if (c == 3) begin
                exp_mb = ref_mem[9];
                checks++;
                if (bus.rd_rs !== 4'b0010 || bus.mb_out !== exp_mb) begin
                    failures++;
                    $display("FAIL rstmid_rs got rs=%b mb=%o exp rs=0010 mb=%o", bus.rd_rs, bus.mb_out, exp_mb);
                end
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_idle got busy=%b exp=0", bus.busy);
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        int n, ep;
        int exp_order [5];
`ifdef MEMBUS_ARB_ROTATE_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) set_port(k, 18'(k * 3), 36'd0);
        bus.rq_cyc = 4'b1111; bus.rd_rq = 4'b1111;
        n = 0;
        for (int c = 0; c < 80 && n < 5; c++) begin
            tick();
            if (bus.addr_ack !== 4'd0) begin
                ep = exp_order[n];
                checks++;
                if (bus.addr_ack !== (4'b0001 << ep)) begin
                    failures++;
                    $display("FAIL prio grant%0d got=%b exp=%b", n, bus.addr_ack, 4'b0001 << ep);
                end
                n++;
            end
        end
        checks++;
        if (n != 5) begin
            failures++; $display("FAIL prio_count got=%0d exp=5", n);
        end
        clear_inputs();
        n = 0;
        while (bus.busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL prio_drain got busy=%b exp=0", bus.busy);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] v;
        for (int i = 0; i < 256; i++) begin
            v = {4'($urandom), $urandom};
            core_mem[i] = v;
            ref_mem[i]  = v;
        end
        exp_mb = '0;
        test_reset();
        test_ignored();
        test_read_only();
        test_rmw();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/membus_arb.md
MEMBUS_ARB -- requirements
Module: membus_arb

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clock `clk`, reset `reset`, where `reset` is asynchronous and active-high.
REQ-002 Port list (name, direction, width, meaning):
- clk  in  1  system clock
- reset  in  1  async active-high reset
- rq_cyc  in  4  per-port memory cycle request, bit N = port N
- rd_rq  in  4  per-port read requested
- wr_rq  in  4  per-port write requested
- ma_p0..ma_p3  in  18 each  per-port word address
- mb_in_p0..mb_in_p3  in  36 each  per-port write data
- wr_rs  in  4  per-port write data ready (write restart)
- addr_ack  out  4  one-cycle grant/address-accepted pulse
- rd_rs  out  4  one-cycle read-data-valid pulse (read restart)
- mb_out  out  36  read data to requesters
- busy  out  1  high in every state except IDLE
- core_addr  out  18  core array address
- core_rd  out  1  core read strobe; data returns on core_rdata next cycle
- core_we  out  1  core write strobe
- core_wdata  out  36  core write data
- core_rdata  in  36  core read data

Function
REQ-003 The block SHALL share one core array between 4 ports, one memory cycle at a time.
REQ-004 States SHALL be IDLE, ACK, RDW, RS, WWAIT, WR, REC.
REQ-005 In IDLE, at each clk edge, the eligible set SHALL be the ports with rq_cyc=1 and (rd_rq|wr_rq)=1; ports with rq_cyc=1 and neither rd_rq nor wr_rq set SHALL be ignored.
REQ-006 If the eligible set is non-empty, the block SHALL latch the winning port, its ma, rd_rq and wr_rq, then enter ACK.
REQ-007 In ACK, addr_ack[port] SHALL be 1 and core_addr SHALL equal the latched address.
- core_rd SHALL equal the latched rd flag.
- Next state: RDW if rd, else WWAIT.
REQ-008 In RDW, the block SHALL capture core_rdata into an internal 36-bit buffer, then enter RS.
REQ-009 In RS, rd_rs[port] SHALL be 1 and mb_out SHALL equal the buffer.
- Next state: WWAIT if wr, else WR (restore of the read data).
REQ-010 In WWAIT, the block SHALL hold until wr_rs[port]=1, then latch mb_in_p<port> into the buffer and enter WR.
- wr_rs bits of other ports SHALL be ignored.
- There SHALL be no timeout.
REQ-011 In WR, core_we SHALL be 1, core_wdata SHALL equal the buffer and core_addr SHALL equal the latched address; next state REC.
REQ-012 REC SHALL last exactly 1 cycle and then return to IDLE; no request is sampled in REC.
REQ-013 Cycle counts, taking the IDLE sample edge as E0:
- read-only: addr_ack in cycle 1, rd_rs in cycle 3, core_we in cycle 4, back in IDLE in cycle 6.
- write-only with wr_rs already high: core_we in cycle 3.
REQ-014 A requester dropping rq_cyc after grant SHALL NOT abort the cycle.
REQ-015 Requests arriving while busy=1 SHALL be held off and arbitrated at the next IDLE.
REQ-016 addr_ack, rd_rs, core_rd and core_we SHALL each be 0 outside their defined states.
REQ-017 mb_out SHALL hold its last value outside RS.
REQ-018 Default priority SHALL be fixed: p0 > p1 > p2 > p3.

Reset
REQ-019 Asserting reset SHALL immediately force IDLE from any state, including mid-cycle.
- All strobes, addr_ack and rd_rs SHALL go to 0.
- busy, mb_out, core_addr, core_wdata and the buffer SHALL go to 0.
- The round-robin pointer SHALL go to 3.
REQ-020 A core write interrupted by reset SHALL NOT be replayed.

Configuration
REQ-021 Macro MEMBUS_ARB_ROTATE_EN controls the arbitration policy.
- When defined: round-robin arbitration; search starts at (last_granted+1) mod 4; last_granted updates on each ACK; the pointer resets to 3, so p0 wins first.
- When undefined: fixed priority per REQ-018, and no pointer register exists.

Verification
REQ-022 Read-only: rq_cyc=0001, rd_rq=0001, ma_p0=000034, core holds 36'o111777222666.
- addr_ack=0001 in cycle 1.
- rd_rs=0001 with mb_out=111777222666 in cycle 3.
- core_we in cycle 4 with the same data; busy low in cycle 6.
REQ-023 Read-modify-write: p2 with rd+wr at address 000020, wr_rs[2] raised 5 cycles after rd_rs, mb_in_p2=36'o000000000333.
- The block stays in WWAIT until wr_rs[2].
- core_we follows one cycle later with wdata=000000000333.
REQ-024 Simultaneous requests: rq_cyc=1111, all reads, held continuously.
- Fixed priority: grant order 0,0,0...
- With MEMBUS_ARB_ROTATE_EN: grant order 0,1,2,3,0.
REQ-025 Reset mid-operation: assert reset during WWAIT.
- Outputs are 0 immediately and no core_we occurs.
- After release, a new p1 request is granted normally.
REQ-026 Ignored request: rq_cyc=0100 with rd_rq=wr_rq=0.
- busy stays 0 and addr_ack stays 0 for 10 cycles.
